snn_lif_layer_tdm: RTL and testbench

Time-multiplexed, fully parametrised leaky integrate-and-fire (LIF) layer with an internal memory-mapped parameter and weight store. It replaces the fixed two-layer network and its separate register file. One instance implements one layer of NUM_NEURONS neurons fed by NUM_INPUTS spike lines. It sits behind the SPI slave's wr_en/addr/wr_data/rd_data bus. Layers chain by connecting out_spikes/out_valid of one instance to in_spikes/step_valid of the next.

---
 rtl/snn_lif_layer_tdm.sv | 265 ++++++++++++++++++++++++++
 tb/tb_snn_lif_layer_tdm.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_lif_layer_tdm.sv
// -----------------------------------------------------------------------------
// snn_lif_layer_tdm
//
// One time-multiplexed layer of leaky integrate-and-fire neurons with a
// built-in memory-mapped parameter and weight store.
//
// A timestep is accepted with step_valid/step_ready. Weighted input spikes are
// accumulated one input line per cycle (all neurons in parallel). One update
// cycle applies leak, bias, threshold and refractory handling. The result is
// then held on out_spikes/out_valid until out_ready.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous, active-low reset
//   cfg_wr_en    config write strobe (one word per cycle)
//   cfg_addr     config word address
//   cfg_wr_data  config write data
//   cfg_rd_data  combinational read of cfg_addr (unmapped -> 0)
//   step_valid   timestep request            step_ready  accepting a step
//   in_spikes    presynaptic spikes          input_current  bias for all neurons
//   out_valid    result available            out_ready   result consumed
//   out_spikes   spike vector of the completed step
//   busy         high whenever a step is in flight
//
// Address map
//   0x0000 threshold, 0x0001 leak, 0x0002 reset_potential,
//   0x0003 refractory_cycles, 0x0004 status (bit0 sticky write-dropped, W1C),
//   0x0100 + i*NUM_NEURONS + j  weight from input i to neuron j,
//   0x0200 + j  spike counter of neuron j (only with SNN_LAYER_SPIKE_COUNT_EN).
//
// Optional feature macro: SNN_LAYER_SPIKE_COUNT_EN adds one 16-bit saturating
// spike counter per neuron, cleared by writing its address.
// -----------------------------------------------------------------------------
module snn_lif_layer_tdm #(
    parameter int WIDTH       = 16,
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_NEURONS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_wr_en,
    input  logic [15:0]             cfg_addr,
    input  logic [WIDTH-1:0]        cfg_wr_data,
    output logic [WIDTH-1:0]        cfg_rd_data,
    input  logic                    step_valid,
    output logic                    step_ready,
    input  logic [NUM_INPUTS-1:0]   in_spikes,
    input  logic signed [WIDTH-1:0] input_current,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_NEURONS-1:0]  out_spikes,
    output logic                    busy
);

    localparam int NW    = NUM_INPUTS * NUM_NEURONS;
    localparam int ACC_W = WIDTH + $clog2(NUM_INPUTS) + 1;
    localparam int SUM_W = ACC_W + 2;
    localparam int IDX_W = $clog2(NUM_INPUTS + 1);

    localparam logic [15:0] ADDR_THR    = 16'h0000;
    localparam logic [15:0] ADDR_LEAK   = 16'h0001;
    localparam logic [15:0] ADDR_RPOT   = 16'h0002;
    localparam logic [15:0] ADDR_REFR   = 16'h0003;
    localparam logic [15:0] ADDR_STATUS = 16'h0004;

    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, DONE} state_t;

    state_t state, state_nxt;

    logic signed [WIDTH-1:0] threshold, leak, reset_pot, refr_cycles;
    logic                    status_drop;
    logic signed [WIDTH-1:0] weights [NW];

    logic [IDX_W-1:0]        idx;
    logic [NUM_INPUTS-1:0]   spk_lat;
    logic signed [WIDTH-1:0] cur_lat;
    logic signed [ACC_W-1:0] acc     [NUM_NEURONS];
    logic signed [WIDTH-1:0] w_row   [NUM_NEURONS];
    logic signed [WIDTH-1:0] row_sel [NUM_NEURONS];
    logic signed [WIDTH-1:0] v       [NUM_NEURONS];
    logic [WIDTH-1:0]        refr    [NUM_NEURONS];

    logic signed [SUM_W-1:0] sum      [NUM_NEURONS];
    logic signed [WIDTH-1:0] sat      [NUM_NEURONS];
    logic signed [WIDTH-1:0] v_nxt    [NUM_NEURONS];
    logic [WIDTH-1:0]        refr_nxt [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]  spike_nxt;
    logic [WIDTH-1:0]        refr_load;

    logic cnt_addr, wr_ok, wr_drop;

    assign busy       = (state != IDLE);
    assign step_ready = (state == IDLE);
    assign out_valid  = (state == DONE);

`ifdef SNN_LAYER_SPIKE_COUNT_EN
    logic [15:0] spike_cnt [NUM_NEURONS];

    always_comb begin
        cnt_addr = 1'b0;
        for (int j = 0; j < NUM_NEURONS; j++)
            if (cfg_addr == 16'(16'h0200 + j)) cnt_addr = 1'b1;
    end

    // Counter clears bypass the busy check; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < NUM_NEURONS; j++) spike_cnt[j] <= '0;
        end else begin
            for (int j = 0; j < NUM_NEURONS; j++) begin
                if (cfg_wr_en && cfg_addr == 16'(16'h0200 + j))
                    spike_cnt[j] <= '0;
                else if (state == UPDATE && spike_nxt[j] && spike_cnt[j] != 16'hFFFF)
                    spike_cnt[j] <= spike_cnt[j] + 16'd1;
            end
        end
    end
`else
    assign cnt_addr = 1'b0;
`endif

    assign wr_ok   = cfg_wr_en && !busy;
    assign wr_drop = cfg_wr_en && busy && !cnt_addr;

    // Parameter and weight store.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            threshold   <= WIDTH'(256);
            leak        <= '0;
            reset_pot   <= '0;
            refr_cycles <= '0;
            status_drop <= 1'b0;
            // NOTE: weights live in flops rather than a RAM macro, which is what allows them to be cleared by reset.
            for (int k = 0; k < NW; k++) weights[k] <= '0;
        end else begin
            if (wr_drop)
                status_drop <= 1'b1;
            else if (wr_ok && cfg_addr == ADDR_STATUS && cfg_wr_data[0])
                status_drop <= 1'b0;

            if (wr_ok) begin
                if (cfg_addr == ADDR_THR)  threshold   <= cfg_wr_data;
                if (cfg_addr == ADDR_LEAK) leak        <= cfg_wr_data;
                if (cfg_addr == ADDR_RPOT) reset_pot   <= cfg_wr_data;
                if (cfg_addr == ADDR_REFR) refr_cycles <= cfg_wr_data;
                for (int k = 0; k < NW; k++)
                    if (cfg_addr == 16'(16'h0100 + k)) weights[k] <= cfg_wr_data;
            end
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cfg_rd_data = '0;
        if (cfg_addr == ADDR_THR)    cfg_rd_data = threshold;
        if (cfg_addr == ADDR_LEAK)   cfg_rd_data = leak;
        if (cfg_addr == ADDR_RPOT)   cfg_rd_data = reset_pot;
        if (cfg_addr == ADDR_REFR)   cfg_rd_data = refr_cycles;
        if (cfg_addr == ADDR_STATUS) cfg_rd_data = {{(WIDTH-1){1'b0}}, status_drop};
        for (int k = 0; k < NW; k++)
            if (cfg_addr == 16'(16'h0100 + k)) cfg_rd_data = weights[k];
`ifdef SNN_LAYER_SPIKE_COUNT_EN
        for (int j = 0; j < NUM_NEURONS; j++)
            if (cfg_addr == 16'(16'h0200 + j)) cfg_rd_data = WIDTH'(spike_cnt[j]);
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // ACCUM visits idx 0..NUM_INPUTS: the weight row is fetched one cycle ahead
    // of its addition, so the extra final cycle only drains the last row.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (step_valid) state_nxt = ACCUM;
            ACCUM:   if (idx == IDX_W'(NUM_INPUTS)) state_nxt = UPDATE;
            UPDATE:  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Weight row for the current input, zero when that input did not spike.
    always_comb begin
        for (int j = 0; j < NUM_NEURONS; j++) row_sel[j] = '0;
        for (int i = 0; i < NUM_INPUTS; i++)
            if (idx == IDX_W'(i) && spk_lat[i])
                for (int j = 0; j < NUM_NEURONS; j++) row_sel[j] = weights[i*NUM_NEURONS + j];
    end

    assign refr_load = refr_cycles[WIDTH-1] ? '0 : refr_cycles;

    // Per-neuron membrane update; parameters are taken live from the store.
    always_comb begin
        spike_nxt = '0;
        for (int j = 0; j < NUM_NEURONS; j++) begin
            sum[j] = SUM_W'(v[j]) - SUM_W'(leak) + SUM_W'(acc[j]) + SUM_W'(cur_lat);
            if (sum[j] > SAT_MAX)      sat[j] = {1'b0, {(WIDTH-1){1'b1}}};
            else if (sum[j] < SAT_MIN) sat[j] = {1'b1, {(WIDTH-1){1'b0}}};
            else                       sat[j] = sum[j][WIDTH-1:0];

            v_nxt[j]    = sat[j];
            refr_nxt[j] = refr[j];
            if (refr[j] != '0) begin
                refr_nxt[j] = refr[j] - WIDTH'(1);
                v_nxt[j]    = reset_pot;
            end else if (sat[j] >= threshold) begin
                spike_nxt[j] = 1'b1;
                v_nxt[j]     = reset_pot;
                refr_nxt[j]  = refr_load;
            end
        end
    end

    // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx        <= '0;
            spk_lat    <= '0;
            cur_lat    <= '0;
            out_spikes <= '0;
            for (int j = 0; j < NUM_NEURONS; j++) begin
                acc[j]   <= '0;
                w_row[j] <= '0;
                v[j]     <= '0;
                refr[j]  <= '0;
            end
        end else begin
            unique case (state)
                IDLE: if (step_valid) begin
                    spk_lat <= in_spikes;
                    cur_lat <= input_current;
                    idx     <= '0;
                    for (int j = 0; j < NUM_NEURONS; j++) begin
                        acc[j]   <= '0;
                        w_row[j] <= '0;
                    end
                end
                ACCUM: begin
                    idx <= idx + IDX_W'(1);
                    for (int j = 0; j < NUM_NEURONS; j++) begin
                        acc[j]   <= acc[j] + ACC_W'(w_row[j]);
                        w_row[j] <= row_sel[j];
                    end
                end
                UPDATE: begin
                    out_spikes <= spike_nxt;
                    for (int j = 0; j < NUM_NEURONS; j++) begin
                        v[j]    <= v_nxt[j];
                        refr[j] <= refr_nxt[j];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_lif_layer_tdm.sv
// -----------------------------------------------------------------------------
// tb_snn_lif_layer_tdm
//
// Self-checking bench for snn_lif_layer_tdm (WIDTH=16, 4 inputs, 3 neurons).
// A behavioural LIF model (plain integer arithmetic) tracks membrane
// potentials, refractory counters, parameters and weights, and supplies the
// expected spike vectors for every step.
// -----------------------------------------------------------------------------
module tb_snn_lif_layer_tdm;

    localparam int W   = 16;
    localparam int NI  = 4;
    localparam int NN  = 3;
    localparam int LAT = NI + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_wr_en = 1'b0;
    logic [15:0]   cfg_addr = '0;
    logic [W-1:0]  cfg_wr_data = '0;
    logic [W-1:0]  cfg_rd_data;
    logic          step_valid = 1'b0;
    logic          step_ready;
    logic [NI-1:0] in_spikes = '0;
    logic [W-1:0]  input_current = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [NN-1:0] out_spikes;
    logic          busy;

    int errors = 0;
    int checks = 0;

    int m_thr, m_leak, m_rpot, m_refrc;
    int m_v    [NN];
    int m_refr [NN];
    int m_w    [NI][NN];

    snn_lif_layer_tdm #(.WIDTH(W), .NUM_INPUTS(NI), .NUM_NEURONS(NN)) dut (
        .clk(clk), .rst(rst),
        .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr),
        .cfg_wr_data(cfg_wr_data), .cfg_rd_data(cfg_rd_data),
        .step_valid(step_valid), .step_ready(step_ready),
        .in_spikes(in_spikes), .input_current(input_current),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_spikes(out_spikes), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_thr = 256; m_leak = 0; m_rpot = 0; m_refrc = 0;
        for (int j = 0; j < NN; j++) begin
            m_v[j] = 0; m_refr[j] = 0;
            for (int i = 0; i < NI; i++) m_w[i][j] = 0;
        end
    endtask

    task automatic model_cfg(input logic [15:0] a, input logic [15:0] d);
        int val;
        val = int'($signed(d));
        if (a == 16'h0000) m_thr = val;
        if (a == 16'h0001) m_leak = val;
        if (a == 16'h0002) m_rpot = val;
        if (a == 16'h0003) m_refrc = val;
        if (a >= 16'h0100 && a < 16'(16'h0100 + NI*NN))
            m_w[(int'(a) - 256) / NN][(int'(a) - 256) % NN] = val;
    endtask

    task automatic model_step(input logic [NI-1:0] sp, input int cur, output logic [NN-1:0] spk);
        longint s;
        spk = '0;
        for (int j = 0; j < NN; j++) begin
            if (m_refr[j] > 0) begin
                m_refr[j]--;
                m_v[j] = m_rpot;
            end else begin
                s = longint'(m_v[j]) - m_leak + cur;
                for (int i = 0; i < NI; i++) if (sp[i]) s += m_w[i][j];
                if (s > 32767) s = 32767;
                if (s < -32768) s = -32768;
                if (s >= m_thr) begin
                    spk[j] = 1'b1;
                    m_v[j] = m_rpot;
                    m_refr[j] = (m_refrc > 0) ? m_refrc : 0;
                end else begin
                    m_v[j] = int'(s);
                end
            end
        end
    endtask

    // ---------------- bus helpers ----------------
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        #12;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic cfg_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        cfg_wr_en = 1'b1; cfg_addr = a; cfg_wr_data = d;
        @(posedge clk);
        #1 cfg_wr_en = 1'b0;
    endtask

    task automatic cfg_set(input logic [15:0] a, input logic [15:0] d);
        cfg_write(a, d);
        model_cfg(a, d);
    endtask

    task automatic cfg_read(input logic [15:0] a, output logic [15:0] d);
        cfg_addr = a;
        #1 d = cfg_rd_data;
    endtask

    // Drives one request; returns 1 ns after the accepting edge with inputs scrambled.
    task automatic start_step(input logic [NI-1:0] sp, input int cur,
                              input logic wr, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        step_valid = 1'b1; in_spikes = sp; input_current = 16'(cur);
        cfg_wr_en = wr; cfg_addr = a; cfg_wr_data = d;
        @(posedge clk);
        #1;
        step_valid = 1'b0; cfg_wr_en = 1'b0;
        in_spikes = NI'($urandom); input_current = 16'($urandom);
    endtask

    // Counts rising edges after acceptance until out_valid is seen (bounded).
    task automatic wait_out(output int lat, output bit to);
        lat = 0; to = 1'b0;
        @(negedge clk);
        while (out_valid !== 1'b1) begin
            if (lat >= 40) begin to = 1'b1; break; end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic do_step(input logic [NI-1:0] sp, input int cur,
                           output logic [NN-1:0] spk, output int lat);
        bit to;
        start_step(sp, cur, 1'b0, 16'h0, 16'h0);
        wait_out(lat, to);
        spk = out_spikes;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [15:0] d;
        apply_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_spikes !== 3'b000) begin errors++; $display("FAIL reset_out_spikes: got %b want 000", out_spikes); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (step_ready !== 1'b1) begin errors++; $display("FAIL reset_step_ready: got %b want 1", step_ready); end
        cfg_read(16'h0000, d);
        checks++; if (d !== 16'd256) begin errors++; $display("FAIL reset_threshold: got %0d want 256", d); end
        cfg_read(16'h0001, d);
        checks++; if (d !== 16'd0) begin errors++; $display("FAIL reset_leak: got %0d want 0", d); end
        cfg_read(16'h0105, d);
        checks++; if (d !== 16'd0) begin errors++; $display("FAIL reset_weight: got %0d want 0", d); end
        cfg_read(16'h0200, d);
        checks++; if (d !== 16'd0) begin errors++; $display("FAIL reset_counter: got %0d want 0", d); end
        cfg_read(16'h0300, d);
        checks++; if (d !== 16'd0) begin errors++; $display("FAIL unmapped_read: got %0h want 0", d); end
    endtask

    task automatic test_refractory();
        logic [5:0]    exp0;
        logic [NN-1:0] spk, mspk;
        int lat;
        apply_reset();
        cfg_set(16'h0000, 16'd100);
        cfg_set(16'h0003, 16'd2);
        cfg_set(16'h0100, 16'd60);
        exp0 = 6'b100010;  // step s expects exp0[s]: 0,1,0,0,0 then 1 (v was 60)
        for (int s = 0; s < 6; s++) begin
            do_step(4'b0001, 0, spk, lat);
            model_step(4'b0001, 0, mspk);
            checks++; if (spk[0] !== exp0[s]) begin errors++; $display("FAIL refractory_n0 step%0d: got %b want %b", s+1, spk[0], exp0[s]); end
            checks++; if (spk !== mspk) begin errors++; $display("FAIL refractory_vec step%0d: got %b want %b", s+1, spk, mspk); end
            if (s == 0) begin
                checks++; if (lat !== LAT) begin errors++; $display("FAIL step_latency: got %0d want %0d", lat, LAT); end
            end
        end
    endtask

    task automatic test_leak_bias();
        logic [NN-1:0] spk, mspk, want;
        int lat;
        apply_reset();
        cfg_set(16'h0001, 16'd10);
        cfg_set(16'h0000, 16'd100);
        for (int s = 0; s < 5; s++) begin
            logic [NI-1:0] sp;
            sp = NI'($urandom);
            do_step(sp, 30, spk, lat);
            model_step(sp, 30, mspk);
            want = (s == 4) ? 3'b111 : 3'b000;
            checks++; if (spk !== want) begin errors++; $display("FAIL leak_bias step%0d: got %b want %b", s+1, spk, want); end
            checks++; if (spk !== mspk) begin errors++; $display("FAIL leak_bias_model step%0d: got %b want %b", s+1, spk, mspk); end
        end
    endtask

    task automatic test_saturation();
        logic [NN-1:0] spk, mspk;
        int lat;
        apply_reset();
        for (int k = 0; k < NI*NN; k++) cfg_set(16'(16'h0100 + k), 16'h7FFF);
        cfg_set(16'h0000, 16'h7FFF);
        for (int s = 0; s < 2; s++) begin
            do_step(4'b1111, 32767, spk, lat);
            model_step(4'b1111, 32767, mspk);
            checks++; if (spk !== 3'b111) begin errors++; $display("FAIL sat_pos step%0d: got %b want 111", s+1, spk); end
            checks++; if (spk !== mspk) begin errors++; $display("FAIL sat_pos_model step%0d: got %b want %b", s+1, spk, mspk); end
        end
        // Negative side: clamps to -32768, which stays below a threshold of -32767.
        for (int k = 0; k < NI*NN; k++) cfg_set(16'(16'h0100 + k), 16'h8000);
        cfg_set(16'h0000, 16'h8001);
        do_step(4'b1111, -32768, spk, lat);
        model_step(4'b1111, -32768, mspk);
        checks++; if (spk !== 3'b000) begin errors++; $display("FAIL sat_neg: got %b want 000", spk); end
        checks++; if (spk !== mspk) begin errors++; $display("FAIL sat_neg_model: got %b want %b", spk, mspk); end
    endtask

    task automatic test_dropped_write();
        logic [15:0]   d;
        logic [NN-1:0] mspk;
        int lat;
        bit to;
        apply_reset();
        cfg_set(16'h0100, 16'd5);
        // Write on the accepting edge must land.
        start_step(4'b0011, 0, 1'b1, 16'h0101, 16'd7);
        model_cfg(16'h0101, 16'd7);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_step: got %b want 1", busy); end
        cfg_wr_en = 1'b1; cfg_addr = 16'h0100; cfg_wr_data = 16'd99;
        @(posedge clk);
        #1 cfg_wr_en = 1'b0;
        wait_out(lat, to);
        checks++; if (to) begin errors++; $display("FAIL dropped_step_timeout: got timeout want out_valid"); end
        model_step(4'b0011, 0, mspk);
        checks++; if (out_spikes !== mspk) begin errors++; $display("FAIL dropped_step_spikes: got %b want %b", out_spikes, mspk); end
        @(posedge clk);
        #1;
        cfg_read(16'h0100, d);
        checks++; if (d !== 16'd5) begin errors++; $display("FAIL dropped_weight: got %0d want 5", d); end
        cfg_read(16'h0101, d);
        checks++; if (d !== 16'd7) begin errors++; $display("FAIL accept_cycle_write: got %0d want 7", d); end
        cfg_read(16'h0004, d);
        checks++; if (d !== 16'd1) begin errors++; $display("FAIL status_set: got %0d want 1", d); end
        cfg_write(16'h0004, 16'd1);
        cfg_read(16'h0004, d);
        checks++; if (d !== 16'd0) begin errors++; $display("FAIL status_clear: got %0d want 0", d); end
    endtask

    task automatic test_backpressure();
        logic [NN-1:0] mspk, held;
        int lat;
        bit to;
        apply_reset();
        cfg_set(16'h0000, 16'd50);
        cfg_set(16'h0100, 16'd60);
        cfg_set(16'h0105, 16'd70);
        out_ready = 1'b0;
        start_step(4'b0011, 0, 1'b0, 16'h0, 16'h0);
        wait_out(lat, to);
        model_step(4'b0011, 0, mspk);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL bp_latency: got %0d want %0d", lat, LAT); end
        checks++; if (out_spikes !== mspk) begin errors++; $display("FAIL bp_spikes: got %b want %b", out_spikes, mspk); end
        held = out_spikes;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_spikes !== held || step_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle%0d: got valid=%b spikes=%b ready=%b want 1/%b/0",
                         k, out_valid, out_spikes, step_ready, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0 || step_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", out_valid, step_ready); end
    endtask

    task automatic test_random();
        logic [NN-1:0] spk, mspk;
        logic [NI-1:0] sp;
        int lat, cur;
        apply_reset();
        cfg_set(16'h0000, 16'($urandom_range(400, 50)));
        cfg_set(16'h0001, 16'($urandom_range(20)));
        cfg_set(16'h0002, 16'(int'($urandom_range(100)) - 50));
        cfg_set(16'h0003, 16'(int'($urandom_range(5)) - 2));
        for (int k = 0; k < NI*NN; k++) cfg_set(16'(16'h0100 + k), 16'(int'($urandom_range(300)) - 100));
        for (int s = 0; s < 24; s++) begin
            sp  = NI'($urandom);
            cur = int'($urandom_range(150)) - 50;
            do_step(sp, cur, spk, lat);
            model_step(sp, cur, mspk);
            checks++; if (spk !== mspk) begin errors++; $display("FAIL random step%0d: got %b want %b (sp=%b cur=%0d)", s, spk, mspk, sp, cur); end
            checks++; if (lat !== LAT) begin errors++; $display("FAIL random_latency step%0d: got %0d want %0d", s, lat, LAT); end
        end
    endtask

    task automatic test_reset_mid_step();
        logic [15:0]   d;
        logic [NN-1:0] spk, mspk;
        int lat, seen;
        apply_reset();
        cfg_set(16'h0000, 16'd20);
        cfg_set(16'h0100, 16'd60);
        do_step(4'b0001, 0, spk, lat);
        start_step(4'b0001, 0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || step_ready !== 1'b1) begin errors++; $display("FAIL midreset_ctrl: got valid=%b busy=%b ready=%b want 0/0/1", out_valid, busy, step_ready); end
        cfg_read(16'h0000, d);
        checks++; if (d !== 16'd256) begin errors++; $display("FAIL midreset_threshold: got %0d want 256", d); end
        cfg_read(16'h0100, d);
        checks++; if (d !== 16'd0) begin errors++; $display("FAIL midreset_weight: got %0d want 0", d); end
        cfg_read(16'h0200, d);
        checks++; if (d !== 16'd0) begin errors++; $display("FAIL midreset_counter: got %0d want 0", d); end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_valid: got %0d valid cycles want 0", seen); end
        do_step(4'b1111, 100, spk, lat);
        model_step(4'b1111, 100, mspk);
        checks++; if (spk !== mspk || lat !== LAT) begin errors++; $display("FAIL post_reset_step: got %b lat %0d want %b lat %0d", spk, lat, mspk, LAT); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_refractory();
        test_leak_bias();
        test_saturation();
        test_dropped_write();
        test_backpressure();
        test_random();
        test_reset_mid_step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion want finish");
        $fatal(1);
    end

endmodule
